// File: rtl/cnn_layer_accel_octo_feeder.sv
// Feeds one octo per frame: num_seq_words sequencer words, then rows*cols pixel words, all
// pulled from an upstream valid/ready stream through one tagged output register (1-cycle latency).
module cnn_layer_accel_octo_feeder #(
   parameter int C_PIXEL_WIDTH      = 18,
   parameter int C_SEQ_DATA_WIDTH   = 13,
   parameter int C_BRAM_DEPTH       = 1024,
   localparam int C_LOG2_BRAM_DEPTH = $clog2(C_BRAM_DEPTH),
   localparam int C_SEQ_CNT_WIDTH   = $clog2((C_BRAM_DEPTH/2)*5)+1
) (
   input  logic                         clk_500MHz,
   input  logic                         rst,
   input  logic                         start,
   input  logic [C_SEQ_CNT_WIDTH-1:0]   cfg_num_seq_words,
   input  logic [C_LOG2_BRAM_DEPTH-1:0] cfg_num_rows,
   input  logic [C_LOG2_BRAM_DEPTH-1:0] cfg_num_cols,
   output logic                         busy,
   output logic                         done,
   input  logic [C_PIXEL_WIDTH-1:0]     src_data,
   input  logic                         src_valid,
   output logic                         src_ready,
   output logic [C_PIXEL_WIDTH-1:0]     datain,
   output logic                         datain_valid,
   output logic                         seq_datain_tag,
   output logic                         pixel_datain_tag,
   input  logic                         seq_datain_rdy,
   input  logic                         pixel_datain_rdy
);

   localparam int C_PIX_CNT_WIDTH = 2*C_LOG2_BRAM_DEPTH;

   typedef enum logic [4:0] {
      ST_IDLE  = 5'b00001,
      ST_SEQ   = 5'b00010,
      ST_PIX   = 5'b00100,
      ST_DRAIN = 5'b01000,
      ST_DONE  = 5'b10000
   } state_t;

   state_t                     state_q, state_d;
   logic [C_SEQ_CNT_WIDTH-1:0] num_seq_q, num_seq_d, seq_cnt_q, seq_cnt_d;
   logic [C_PIX_CNT_WIDTH-1:0] pix_total_q, pix_total_d, pix_cnt_q, pix_cnt_d;
   logic [C_PIX_CNT_WIDTH-1:0] pix_total_calc;
   logic [C_PIXEL_WIDTH-1:0]   dat_q, dat_d, seq_ext;
   logic                       vld_q, vld_d, seq_tag_q, seq_tag_d, pix_tag_q, pix_tag_d;
   logic                       rdy_sel, out_fire, src_fire, in_phase, seq_last, pix_last;

   assign pix_total_calc = C_PIX_CNT_WIDTH'(cfg_num_rows) * C_PIX_CNT_WIDTH'(cfg_num_cols);
   assign rdy_sel        = seq_tag_q ? seq_datain_rdy : pixel_datain_rdy;
   assign out_fire       = vld_q & rdy_sel;
   assign in_phase       = (state_q == ST_SEQ) | (state_q == ST_PIX);
   assign src_ready      = in_phase & (~vld_q | out_fire);
   assign src_fire       = src_valid & src_ready;
   assign seq_last       = (seq_cnt_q == num_seq_q - C_SEQ_CNT_WIDTH'(1));
   assign pix_last       = (pix_cnt_q == pix_total_q - C_PIX_CNT_WIDTH'(1));

   assign busy             = (state_q != ST_IDLE);
   assign done             = (state_q == ST_DONE);
   assign datain           = dat_q;
   assign datain_valid     = vld_q;
   assign seq_datain_tag   = seq_tag_q;
   assign pixel_datain_tag = pix_tag_q;

   always_comb begin
      state_d     = state_q;
      num_seq_d   = num_seq_q;
      pix_total_d = pix_total_q;
      seq_cnt_d   = seq_cnt_q;
      pix_cnt_d   = pix_cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               num_seq_d   = cfg_num_seq_words;
               pix_total_d = pix_total_calc;
               seq_cnt_d   = '0;
               pix_cnt_d   = '0;
               if (cfg_num_seq_words != '0)   state_d = ST_SEQ;
               else if (pix_total_calc != '0) state_d = ST_PIX;
               else                           state_d = ST_DONE;
            end
         end
         ST_SEQ: begin
            if (src_fire) begin
               seq_cnt_d = seq_cnt_q + C_SEQ_CNT_WIDTH'(1);
               if (seq_last) state_d = (pix_total_q != '0) ? ST_PIX : ST_DRAIN;
            end
         end
         ST_PIX: begin
            if (src_fire) begin
               pix_cnt_d = pix_cnt_q + C_PIX_CNT_WIDTH'(1);
               if (pix_last) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: if (!vld_q) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // A new word may replace the accepted one in the same cycle, so load wins over unload.
   always_comb begin
      seq_ext                         = '0;
      seq_ext[C_SEQ_DATA_WIDTH-1:0]   = src_data[C_SEQ_DATA_WIDTH-1:0];
      dat_d     = dat_q;
      vld_d     = vld_q;
      seq_tag_d = seq_tag_q;
      pix_tag_d = pix_tag_q;
      if (src_fire) begin
         dat_d     = (state_q == ST_SEQ) ? seq_ext : src_data;
         vld_d     = 1'b1;
         seq_tag_d = (state_q == ST_SEQ);
         pix_tag_d = (state_q == ST_PIX);
      end else if (out_fire) begin
         vld_d     = 1'b0;
         seq_tag_d = 1'b0;
         pix_tag_d = 1'b0;
      end
   end

   always_ff @(posedge clk_500MHz or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         num_seq_q   <= '0;
         pix_total_q <= '0;
         seq_cnt_q   <= '0;
         pix_cnt_q   <= '0;
         dat_q       <= '0;
         vld_q       <= 1'b0;
         seq_tag_q   <= 1'b0;
         pix_tag_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         num_seq_q   <= num_seq_d;
         pix_total_q <= pix_total_d;
         seq_cnt_q   <= seq_cnt_d;
         pix_cnt_q   <= pix_cnt_d;
         dat_q       <= dat_d;
         vld_q       <= vld_d;
         seq_tag_q   <= seq_tag_d;
         pix_tag_q   <= pix_tag_d;
      end
   end

endmodule

// File: tb/tb_cnn_layer_accel_octo_feeder.sv
// Scoreboard bench for the octo feeder: the source driver pushes expected words on each
// accepted source word; a negedge monitor pops them on every octo-side transfer.
module tb_cnn_layer_accel_octo_feeder;

   localparam int PW = 18;
   localparam int SW = 13;
   localparam int BD = 1024;
   localparam int LW = $clog2(BD);
   localparam int CW = $clog2((BD/2)*5)+1;
   localparam logic [PW-1:0] SEQ_MASK = 18'h01FFF;

   typedef struct packed {
      logic          is_seq;
      logic [PW-1:0] val;
      logic [PW-1:0] exp;
   } word_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [CW-1:0] cfg_num_seq_words = '0;
   logic [LW-1:0] cfg_num_rows = '0;
   logic [LW-1:0] cfg_num_cols = '0;
   logic          busy, done, src_ready, datain_valid, seq_datain_tag, pixel_datain_tag;
   logic [PW-1:0] src_data = '0;
   logic          src_valid = 1'b0;
   logic [PW-1:0] datain;
   logic          seq_datain_rdy = 1'b1;
   logic          pixel_datain_rdy = 1'b1;

   cnn_layer_accel_octo_feeder #(
      .C_PIXEL_WIDTH(PW), .C_SEQ_DATA_WIDTH(SW), .C_BRAM_DEPTH(BD)
   ) dut (
      .clk_500MHz(clk), .rst(rst), .start(start),
      .cfg_num_seq_words(cfg_num_seq_words), .cfg_num_rows(cfg_num_rows),
      .cfg_num_cols(cfg_num_cols), .busy(busy), .done(done),
      .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
      .datain(datain), .datain_valid(datain_valid), .seq_datain_tag(seq_datain_tag),
      .pixel_datain_tag(pixel_datain_tag), .seq_datain_rdy(seq_datain_rdy),
      .pixel_datain_rdy(pixel_datain_rdy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   word_t         src_q[$];
   logic [PW:0]   sb_q[$];

   // Octo-side monitor
   int            cyc = 0;
   int            out_cnt = 0;
   int            done_cnt = 0;
   int            first_fire_cyc = -1;
   int            last_fire_cyc = 0;
   int            done_cyc = 0;
   bit            any_vld = 0;
   bit            any_seq = 0;
   bit            prev_stall = 0;
   logic [PW-1:0] prev_dat;
   logic          prev_seq, prev_pix, sel;
   logic [PW:0]   e;

   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         prev_stall = 0;
      end else begin
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (datain_valid) begin
            any_vld = 1;
            if (seq_datain_tag) any_seq = 1;
            chk("tag_onehot", {seq_datain_tag, pixel_datain_tag}, seq_datain_tag ? 2'b10 : 2'b01);
            if (prev_stall) begin
               chk("stall_data_stable", datain, prev_dat);
               chk("stall_tag_stable", {seq_datain_tag, pixel_datain_tag}, {prev_seq, prev_pix});
            end
            sel = seq_datain_tag ? seq_datain_rdy : pixel_datain_rdy;
            if (sel) begin
               out_cnt++;
               last_fire_cyc = cyc;
               if (first_fire_cyc < 0) first_fire_cyc = cyc;
               if (sb_q.size() == 0) begin
                  chk("sb_underflow", 1, 0);
               end else begin
                  e = sb_q.pop_front();
                  chk("out_word", {seq_datain_tag, datain}, e);
               end
            end else begin
               chk("stall_src_ready", src_ready, 0);
            end
            prev_stall = !sel;
            prev_dat   = datain;
            prev_seq   = seq_datain_tag;
            prev_pix   = pixel_datain_tag;
         end else begin
            chk("idle_tags", {seq_datain_tag, pixel_datain_tag}, 2'b00);
            prev_stall = 0;
         end
      end
   end

   task automatic push_word(input logic is_seq, input logic [PW-1:0] val, input logic [PW-1:0] exp);
      word_t w;
      w.is_seq = is_seq;
      w.val    = val;
      w.exp    = exp;
      src_q.push_back(w);
   endtask

   task automatic fill_auto(input int nseq, input int npix);
      logic [PW-1:0] v;
      for (int i = 0; i < nseq; i++) begin
         v = PW'(32'h2E000 + i*7);
         push_word(1'b1, v, v & SEQ_MASK);
      end
      for (int i = 0; i < npix; i++) begin
         v = PW'(32'h30000 + i*5);
         push_word(1'b0, v, v);
      end
   endtask

   // All tasks enter and leave one time unit after a rising edge.
   task automatic start_frame(input int nseq, input int rows, input int cols);
      cfg_num_seq_words = CW'(nseq);
      cfg_num_rows      = LW'(rows);
      cfg_num_cols      = LW'(cols);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_start", busy, 1);
   endtask

   task automatic stream(input int budget, input int pat_mode, input int poke, input int abort_outs);
      int c;
      int base_out;
      c = 0;
      base_out = out_cnt;
      while (src_q.size() > 0 && c < budget) begin
         if (abort_outs > 0 && out_cnt - base_out >= abort_outs) break;
         if (pat_mode == 2 && c == 6) chk("wrong_rdy_no_xfer", out_cnt - base_out, 0);
         case (pat_mode)
            1: pixel_datain_rdy = (c % 4 == 0) || (c % 4 == 3);
            2: begin
               seq_datain_rdy   = (c >= 6);
               pixel_datain_rdy = 1'b1;
            end
            default: ;
         endcase
         if (c == poke) begin
            start = 1'b1;
            cfg_num_seq_words = CW'(1);
            cfg_num_rows = LW'(1);
            cfg_num_cols = LW'(1);
         end else begin
            start = 1'b0;
         end
         src_valid = 1'b1;
         src_data  = src_q[0].val;
         @(negedge clk);
         if (src_ready) begin
            sb_q.push_back({src_q[0].is_seq, src_q[0].exp});
            void'(src_q.pop_front());
         end
         @(posedge clk); #1;
         c++;
      end
      src_valid = 1'b0;
      start = 1'b0;
      seq_datain_rdy = 1'b1;
      pixel_datain_rdy = 1'b1;
      if (abort_outs == 0) chk("stream_complete", src_q.size(), 0);
      else chk("abort_reached", (out_cnt - base_out) >= abort_outs, 1);
   endtask

   task automatic wait_done(input int budget);
      int c;
      bit seen;
      seen = 0;
      c = 0;
      while (!seen && c < budget) begin
         @(negedge clk);
         if (done) seen = 1;
         c++;
      end
      chk("done_seen", seen, 1);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("busy_after_done", busy, 0);
      @(posedge clk); #1;
   endtask

   task automatic run_frame(input int nseq, input int rows, input int cols,
                            input int pat_mode, input int poke, input bit nominal);
      int base_done;
      int base_out;
      int npix;
      npix = rows * cols;
      base_done = done_cnt;
      base_out = out_cnt;
      any_vld = 0;
      any_seq = 0;
      first_fire_cyc = -1;
      if (!nominal) fill_auto(nseq, npix);
      start_frame(nseq, rows, cols);
      stream(4*(nseq + npix) + 40, pat_mode, poke, 0);
      wait_done(60);
      repeat (3) @(posedge clk);
      #1;
      chk("done_count", done_cnt - base_done, 1);
      chk("word_count", out_cnt - base_out, nseq + npix);
      chk("sb_empty", sb_q.size(), 0);
      if (nseq + npix == 0) chk("no_valid_ever", any_vld, 0);
      if (nseq == 0) chk("no_seq_tag", any_seq, 0);
      if (nominal) begin
         chk("nominal_span", last_fire_cyc - first_fire_cyc, 9);
         chk("done_latency", done_cyc - last_fire_cyc, 2);
      end
   endtask

   initial begin
      int base_done;
      // Reset with random inputs
      for (int i = 0; i < 3; i++) begin
         start = 1'($urandom);
         src_valid = 1'($urandom);
         src_data = PW'($urandom);
         seq_datain_rdy = 1'($urandom);
         pixel_datain_rdy = 1'($urandom);
         cfg_num_seq_words = CW'($urandom);
         cfg_num_rows = LW'($urandom);
         cfg_num_cols = LW'($urandom);
         @(negedge clk);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_src_ready", src_ready, 0);
         chk("rst_valid", datain_valid, 0);
         chk("rst_tags", {seq_datain_tag, pixel_datain_tag}, 0);
         chk("rst_datain", datain, 0);
      end
      start = 1'b0;
      src_valid = 1'b0;
      seq_datain_rdy = 1'b1;
      pixel_datain_rdy = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      // Nominal: 4 seq words (upper bits must be dropped), then 2x3 pixels
      push_word(1'b1, 18'h3FFFF, 18'h01FFF);
      push_word(1'b1, 18'h20001, 18'h00001);
      push_word(1'b1, 18'h01234, 18'h01234);
      push_word(1'b1, 18'h2ABCD, 18'h00BCD);
      push_word(1'b0, 18'h3FFFF, 18'h3FFFF);
      push_word(1'b0, 18'h20001, 18'h20001);
      push_word(1'b0, 18'h12345, 18'h12345);
      push_word(1'b0, 18'h00000, 18'h00000);
      push_word(1'b0, 18'h2ABCD, 18'h2ABCD);
      push_word(1'b0, 18'h15555, 18'h15555);
      run_frame(4, 2, 3, 0, -1, 1'b1);

      run_frame(2, 2, 3, 1, -1, 1'b0);   // pixel backpressure 1,0,0,1
      run_frame(3, 1, 2, 2, -1, 1'b0);   // wrong rdy during sequencer phase
      run_frame(0, 1, 1, 0, -1, 1'b0);   // single pixel, no sequencer words
      run_frame(0, 0, 5, 0, -1, 1'b0);   // empty frame
      run_frame(2560, 0, 0, 0, -1, 1'b0);
      run_frame(2, 2, 2, 0, 2, 1'b0);    // start while busy

      // Reset mid-frame after 3 pixels
      base_done = done_cnt;
      fill_auto(0, 8);
      start_frame(0, 2, 4);
      stream(100, 0, -1, 3);
      #2;
      rst = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_src_ready", src_ready, 0);
      chk("abort_valid", datain_valid, 0);
      chk("abort_tags", {seq_datain_tag, pixel_datain_tag}, 0);
      chk("abort_datain", datain, 0);
      sb_q.delete();
      src_q.delete();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_no_done", done_cnt - base_done, 0);
      run_frame(1, 2, 2, 0, -1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      n_fail++;
      $display("FAIL watchdog: simulation exceeded time budget");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cnn_layer_accel_octo_feeder.md
Name: cnn_layer_accel_octo_feeder

Overview:
- Transmit end of the octo input interface. Drives the shared datain bus, datain_valid, seq_datain_tag and pixel_datain_tag into an octo, and obeys its seq_datain_rdy and pixel_datain_rdy.
- Per frame it sends a programmed number of sequencer words, then rows*cols pixel words, pulled from an upstream valid/ready stream.
- Sits between the DMA/host stream and the octo. One instance feeds one octo.

Parameters:
- C_PIXEL_WIDTH, 18, datain/pixel word width.
- C_SEQ_DATA_WIDTH, 13, sequencer word width; must be <= C_PIXEL_WIDTH.
- C_BRAM_DEPTH, 1024, octo row-buffer depth. Sets counter widths: C_LOG2_BRAM_DEPTH = clog2(C_BRAM_DEPTH); C_SEQ_CNT_WIDTH = clog2((C_BRAM_DEPTH/2)*5)+1.

Ports:
- clk_500MHz  in  1  sole clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle frame start request.
- cfg_num_seq_words  in  C_SEQ_CNT_WIDTH  sequencer words this frame.
- cfg_num_rows  in  C_LOG2_BRAM_DEPTH  pixel rows.
- cfg_num_cols  in  C_LOG2_BRAM_DEPTH  pixel columns.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when the final word is accepted by the octo.
- src_data  in  C_PIXEL_WIDTH  upstream word.
- src_valid  in  1  upstream word valid.
- src_ready  out  1  feeder accepts src_data.
- datain  out  C_PIXEL_WIDTH  word to octo.
- datain_valid  out  1  datain valid.
- seq_datain_tag  out  1  current word is a sequencer word.
- pixel_datain_tag  out  1  current word is a pixel.
- seq_datain_rdy  in  1  octo accepts sequencer words.
- pixel_datain_rdy  in  1  octo accepts pixel words.

Behaviour:
- Reset (rst=0, async):
  - Outputs: busy, done, src_ready, datain_valid and both tags clear to 0; datain clears to 0.
  - Internal state: FSM goes to ST_IDLE; counters clear.
  - Reset mid-frame abandons the frame silently: no done pulse.
- FSM states (one-hot): ST_IDLE, ST_SEQ, ST_PIX, ST_DRAIN, ST_DONE.
- ST_IDLE:
  - On start=1, latch the cfg_* inputs and compute pix_total = rows*cols (2*C_LOG2_BRAM_DEPTH bits, unsigned).
  - Go to ST_SEQ if num_seq_words>0; else ST_PIX if pix_total>0; else ST_DONE.
  - start outside ST_IDLE is ignored.
- ST_SEQ / ST_PIX:
  - The source handshake src_fire = src_valid & src_ready increments that phase's counter.
  - After the last sequencer word fires: go to ST_PIX if pix_total>0, else ST_DRAIN.
  - After the last pixel fires: go to ST_DRAIN.
- ST_DRAIN: wait until the output register is empty (final word accepted), then go to ST_DONE.
- ST_DONE: done=1 for exactly one cycle; busy falls on the same edge; next state ST_IDLE.
- busy is 1 in every state except ST_IDLE.
- Output stage (single register holding datain, datain_valid and the tag pair):
  - Word loads on src_fire. Latency from src_fire to datain_valid is 1 cycle.
  - Sequencer words are zero-extended from bits [C_SEQ_DATA_WIDTH-1:0] of src_data.
  - Selected ready: rdy_sel = seq_datain_tag ? seq_datain_rdy : pixel_datain_rdy.
  - Octo handshake: out_fire = datain_valid & rdy_sel.
  - src_ready = (ST_SEQ | ST_PIX) & (~datain_valid | out_fire). This gives full throughput: one word per cycle when rdy_sel is held high.
  - Non-selected rdy has no effect.
- Tag rules:
  - Tags are registered with the word; exactly one tag is high when datain_valid=1; both are 0 when datain_valid=0.
  - datain and the tags are stable while datain_valid=1 & rdy_sel=0.
  - At the seq->pixel boundary, the last sequencer word and the first pixel word may be back-to-back; the tag changes only on the fire edge.
- Counters:
  - The sequencer counter terminates at num_seq_words; the pixel counter at pix_total.
  - Neither counter can wrap, because the FSM leaves the phase on terminal count.
  - Words beyond the programmed count are never accepted (src_ready=0 outside ST_SEQ/ST_PIX).
- Simultaneous events: out_fire and src_fire in the same cycle replace the register contents without a bubble.

Test Plan:
- Reset: hold rst=0 with random inputs -> busy, done, src_ready, datain_valid, both tags and datain all 0. Release, then start -> busy=1 next cycle.
- Nominal frame: seq=4, rows=2, cols=3, src_valid and both rdys held 1 -> 4 seq-tagged words then 6 pixel-tagged words on 10 consecutive cycles, values in order; done pulses once, 1 cycle after ST_DRAIN sees the register empty.
- Backpressure: pixel_datain_rdy toggling 1,0,0,1 with seq_datain_rdy=1 during the pixel phase -> datain and tag held stable while stalled, no word lost or duplicated, src_ready=0 on stall cycles.
- Wrong-rdy isolation: during ST_SEQ set pixel_datain_rdy=1 and seq_datain_rdy=0 -> no transfer. Raising seq_datain_rdy resumes transfer.
- Boundaries:
  - seq=0, rows=1, cols=1 -> single pixel word, no seq tag ever.
  - rows=0 -> done pulse with datain_valid never asserted.
  - seq=2560 (max) -> all 2560 words sent.
  - start while busy -> ignored.
- Reset mid-frame: assert rst low after 3 pixels -> outputs clear immediately, no done pulse. A following full frame completes correctly.
